// File: rtl/midi_msg_parser.sv
// MIDI channel-message parser: one byte per cycle in, one-cycle event pulses out.
// Tracks running status, assembles two-data-byte messages, filters by channel and
// skips SysEx payloads. Real-time bytes pass through without disturbing a message.
module midi_msg_parser #(
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter bit         OMNI    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  output logic       note_on,
  output logic       note_off,
  output logic       param_change_ready,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic       sync_error
);

  typedef enum logic [1:0] {StIdle, StWaitD1, StWaitD2, StSysex} state_e;

  state_e     state_q, state_d;
  logic [7:0] status_q, status_d;
  logic [6:0] d1_q, d1_d;
  logic [6:0] note_q, note_d;
  logic [6:0] vel_q, vel_d;
  logic       on_q, on_d;
  logic       off_q, off_d;
  logic       cc_q, cc_d;
  logic       sync_q, sync_d;

  logic       chan_match;
  logic       two_data;

  assign chan_match = OMNI || (status_q[3:0] == CHANNEL);
  // Program Change / Channel Pressure carry a single data byte and are skipped.
  assign two_data   = (status_q[7:4] == 4'h8) || (status_q[7:4] == 4'h9) ||
                      (status_q[7:4] == 4'hA) || (status_q[7:4] == 4'hB) ||
                      (status_q[7:4] == 4'hE);

  // Next-state decode for parser state, running status and registered events.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    d1_d     = d1_q;
    note_d   = note_q;
    vel_d    = vel_q;
    on_d     = 1'b0;
    off_d    = 1'b0;
    cc_d     = 1'b0;
    sync_d   = 1'b0;

    if (byte_valid) begin
      if (!byte_in[7]) begin
        unique case (state_q)
          StIdle: sync_d = 1'b1;
          StWaitD1: begin
            if (two_data) begin
              d1_d    = byte_in[6:0];
              state_d = StWaitD2;
            end
          end
          StWaitD2: begin
            // Message complete; stay in WAIT_D1 so running status continues.
            state_d = StWaitD1;
            if (chan_match) begin
              case (status_q[7:4])
                4'h8:    off_d = 1'b1;
                4'h9: begin
                  if (byte_in[6:0] != 7'd0) on_d = 1'b1;
                  else                      off_d = 1'b1;
                end
                4'hB:    cc_d = 1'b1;
                default: ;
              endcase
              if (on_d || off_d || cc_d) begin
                note_d = d1_q;
                vel_d  = byte_in[6:0];
              end
            end
          end
          StSysex: ;
        endcase
      end else if (byte_in < 8'hF0) begin
        // Channel status restarts parsing and drops any partial message.
        status_d = byte_in;
        state_d  = StWaitD1;
      end else if (byte_in == 8'hF0) begin
        status_d = 8'h00;
        state_d  = StSysex;
      end else if (byte_in < 8'hF8) begin
        // Remaining system common (incl. 0xF7 end-of-SysEx) cancels running status.
        status_d = 8'h00;
        state_d  = StIdle;
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      status_q <= 8'h00;
      d1_q     <= 7'd0;
      note_q   <= 7'd0;
      vel_q    <= 7'd0;
      on_q     <= 1'b0;
      off_q    <= 1'b0;
      cc_q     <= 1'b0;
      sync_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      d1_q     <= d1_d;
      note_q   <= note_d;
      vel_q    <= vel_d;
      on_q     <= on_d;
      off_q    <= off_d;
      cc_q     <= cc_d;
      sync_q   <= sync_d;
    end
  end

  assign note_on            = on_q;
  assign note_off           = off_q;
  assign param_change_ready = cc_q;
  assign sync_error         = sync_q;
  assign note               = note_q;
  assign velocity           = vel_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed bench for midi_msg_parser with an event scoreboard.
module tb_midi_msg_parser;

  logic       clk;
  logic       rst_n;
  logic       byte_valid;
  logic [7:0] byte_in;
  logic       note_on;
  logic       note_off;
  logic       param_change_ready;
  logic [6:0] note;
  logic [6:0] velocity;
  logic       sync_error;

  localparam logic [1:0] EvOn = 2'd0, EvOff = 2'd1, EvCc = 2'd2, EvSync = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [6:0] n;
    logic [6:0] v;
  } ev_t;

  ev_t q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  midi_msg_parser #(.CHANNEL(4'd0), .OMNI(1'b0)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .byte_valid         (byte_valid),
    .byte_in            (byte_in),
    .note_on            (note_on),
    .note_off           (note_off),
    .param_change_ready (param_change_ready),
    .note               (note),
    .velocity           (velocity),
    .sync_error         (sync_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop and compare one expected event for every pulse the DUT produces.
  always begin
    @(posedge clk);
    #1;
    if (note_on || note_off || param_change_ready || sync_error) begin
      ev_t got;
      ev_t exp;
      got.kind = note_on ? EvOn : note_off ? EvOff : param_change_ready ? EvCc : EvSync;
      got.n    = note;
      got.v    = velocity;
      n_cmp++;
      assert ($onehot0({note_on, note_off, param_change_ready, sync_error})) else begin
        n_err++;
        $error("FAIL onehot pulses=%b required=at most one",
               {note_on, note_off, param_change_ready, sync_error});
      end
      n_cmp++;
      assert (q.size() > 0) else begin
        n_err++;
        $error("FAIL unexpected_event got kind=%0d note=%0d vel=%0d required=none",
               got.kind, got.n, got.v);
      end
      if (q.size() > 0) begin
        exp = q.pop_front();
        n_cmp++;
        assert (got === exp) else begin
          n_err++;
          $error("FAIL event got kind=%0d note=%0d vel=%0d required kind=%0d note=%0d vel=%0d",
                 got.kind, got.n, got.v, exp.kind, exp.n, exp.v);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_in    = b;
  endtask

  task automatic send_exp(input logic [7:0] b, input logic [1:0] k,
                          input logic [6:0] n, input logic [6:0] v);
    ev_t e;
    e.kind = k;
    e.n    = n;
    e.v    = v;
    q.push_back(e);
    send(b);
  endtask

  // Idle a few cycles, then every expected event must have been seen.
  task automatic drain(input string tag);
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    assert (q.size() == 0) else begin
      n_err++;
      $error("FAIL %s missing_events pending=%0d required=0", tag, q.size());
    end
    q.delete();
  endtask

  task automatic check_hold(input string tag, input logic [6:0] n, input logic [6:0] v);
    n_cmp++;
    assert ({note, velocity} === {n, v}) else begin
      n_err++;
      $error("FAIL %s note=%0d vel=%0d required note=%0d vel=%0d", tag, note, velocity, n, v);
    end
  endtask

  task automatic check_zero(input string tag);
    n_cmp++;
    assert ({note_on, note_off, param_change_ready, sync_error, note, velocity} === 18'd0)
      else begin
      n_err++;
      $error("FAIL %s outputs=%h required=0", tag,
             {note_on, note_off, param_change_ready, sync_error, note, velocity});
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Basic Note On.
    send(8'h90); send(8'h3C); send_exp(8'h64, EvOn, 7'd60, 7'd100);
    drain("note_on");
    check_hold("note_on_hold", 7'd60, 7'd100);

    // Running status: Note On then Note On vel 0 -> Note Off.
    send(8'h90); send(8'h3C); send_exp(8'h64, EvOn, 7'd60, 7'd100);
    send(8'h40); send_exp(8'h00, EvOff, 7'd64, 7'd0);
    drain("running_status");
    check_hold("running_hold", 7'd64, 7'd0);

    // Control Change, then one on another channel that must be ignored.
    send(8'hB0); send(8'h18); send_exp(8'h55, EvCc, 7'd24, 7'd85);
    drain("cc");
    send(8'hB3); send(8'h01); send(8'h02);
    drain("cc_other_channel");
    check_hold("cc_hold", 7'd24, 7'd85);

    // Real-time byte inside a message.
    send(8'h90); send(8'h3C); send(8'hF8); send_exp(8'h64, EvOn, 7'd60, 7'd100);
    drain("realtime");

    // Note Off status aborts a partial Note On.
    send(8'h90); send(8'h3C); send(8'h80); send(8'h3C); send_exp(8'h00, EvOff, 7'd60, 7'd0);
    drain("abort");

    // Program Change bytes yield no events.
    send(8'hC0); send(8'h05); send(8'h06);
    drain("prog_change");
    check_hold("pc_hold", 7'd60, 7'd0);

    // Async reset mid-message.
    send(8'h90); send(8'h3C); send_exp(8'h64, EvOn, 7'd60, 7'd100);
    send(8'h90); send(8'h3C);
    @(negedge clk);
    byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send_exp(8'h64, EvSync, 7'd0, 7'd0);
    drain("after_reset");

    // Stray data byte in IDLE.
    send_exp(8'h12, EvSync, 7'd0, 7'd0);
    drain("sync_error");

    // SysEx payload is silent; data after 0xF7 is an error.
    send(8'hF0); send(8'h7E); send(8'h01); send(8'hF7); send_exp(8'h3C, EvSync, 7'd0, 7'd0);
    drain("sysex");
    check_hold("final_hold", 7'd0, 7'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
